// File: rtl/kof_input_decoder.sv
// Keycode-to-action decoder for two fighters. Matches the six GPIO key slots
// against each player's keymap, aligns all decisions to a vsync-derived frame
// tick, and produces level (move/squat) and one-shot (punch/kick/jump) actions
// with per-player lockout counters.
module kof_input_decoder #(
  parameter logic [47:0] P1_KEYMAP    = 48'h07_04_16_1A_0D_0E,
  parameter logic [47:0] P2_KEYMAP    = 48'h50_4F_51_52_59_5A,
  parameter int unsigned ATK_COOLDOWN = 12,
  parameter int unsigned JUMP_LOCK    = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] keycode0_gpio,
  input  logic [31:0] keycode1_gpio,
  input  logic        vsync,
  input  logic        stop,
  output logic        forward_1,
  output logic        back_1,
  output logic        squat_1,
  output logic        punch_1,
  output logic        kick_1,
  output logic        jump_1,
  output logic        forward_2,
  output logic        back_2,
  output logic        squat_2,
  output logic        punch_2,
  output logic        kick_2,
  output logic        jump_2
);

  // Function bit positions follow the keymap packing {fwd,back,squat,jump,punch,kick}.
  localparam int unsigned FKick  = 0;
  localparam int unsigned FPunch = 1;
  localparam int unsigned FJump  = 2;
  localparam int unsigned FSquat = 3;
  localparam int unsigned FBack  = 4;
  localparam int unsigned FFwd   = 5;

  localparam logic [7:0] AtkLoad  = ATK_COOLDOWN[7:0];
  localparam logic [7:0] JumpLoad = JUMP_LOCK[7:0];

  logic [47:0] slots;
  logic        unused_kc1;
  logic [47:0] keymap [2];

  assign slots      = {keycode1_gpio[15:0], keycode0_gpio};
  assign unused_kc1 = ^keycode1_gpio[31:16];
  assign keymap[0]  = P1_KEYMAP;
  assign keymap[1]  = P2_KEYMAP;

  // A zero keycode means "empty slot" and must never count as a press.
  function automatic logic key_match(input logic [7:0] kc, input logic [47:0] sl);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < 6; s++) begin
      if (kc != 8'h00 && sl[s*8 +: 8] == kc) hit = 1'b1;
    end
    return hit;
  endfunction

  logic vs_s1, vs_s2, vs_s3, tick;

  logic [5:0] held   [2];
  logic [5:0] press  [2];
  logic [5:0] prev_q [2];
  logic [5:0] prev_d [2];
  logic [5:0] act_q  [2];
  logic [5:0] act_d  [2];
  logic [7:0] atk_q  [2];
  logic [7:0] atk_d  [2];
  logic [7:0] jmp_q  [2];
  logic [7:0] jmp_d  [2];

  // Bring vsync into the clk domain and keep one extra stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
    end else begin
      vs_s1 <= vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign tick = vs_s2 & ~vs_s3;

  // Per-player held flags from the current GPIO value.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      held[p] = '0;
      for (int f = 0; f < 6; f++) begin
        held[p][f] = key_match(keymap[p][f*8 +: 8], slots);
      end
    end
  end

  // Frame-tick next-state: level actions, one-shot attacks/jump, lockout counters.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      prev_d[p] = prev_q[p];
      act_d[p]  = act_q[p];
      atk_d[p]  = atk_q[p];
      jmp_d[p]  = jmp_q[p];
      press[p]  = held[p] & ~prev_q[p];
      if (tick) begin
        // History tracks keys even while frozen so held keys do not fire on release.
        prev_d[p] = held[p];
        act_d[p]  = '0;
        if (!stop) begin
          act_d[p][FSquat] = held[p][FSquat];
          act_d[p][FFwd]   = held[p][FFwd] & ~held[p][FBack] & ~held[p][FSquat];
          act_d[p][FBack]  = held[p][FBack] & ~held[p][FFwd] & ~held[p][FSquat];

          if (atk_q[p] == 8'd0 && press[p][FPunch]) begin
            act_d[p][FPunch] = 1'b1;
            atk_d[p]         = AtkLoad;
          end else if (atk_q[p] == 8'd0 && press[p][FKick]) begin
            act_d[p][FKick] = 1'b1;
            atk_d[p]        = AtkLoad;
          end else if (atk_q[p] != 8'd0) begin
            atk_d[p] = atk_q[p] - 8'd1;
          end

          if (jmp_q[p] == 8'd0 && press[p][FJump]) begin
            act_d[p][FJump] = 1'b1;
            jmp_d[p]        = JumpLoad;
          end else if (jmp_q[p] != 8'd0) begin
            jmp_d[p] = jmp_q[p] - 8'd1;
          end
        end
      end
    end
  end

  // Per-player state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        prev_q[p] <= '0;
        act_q[p]  <= '0;
        atk_q[p]  <= '0;
        jmp_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        prev_q[p] <= prev_d[p];
        act_q[p]  <= act_d[p];
        atk_q[p]  <= atk_d[p];
        jmp_q[p]  <= jmp_d[p];
      end
    end
  end

  assign forward_1 = act_q[0][FFwd];
  assign back_1    = act_q[0][FBack];
  assign squat_1   = act_q[0][FSquat];
  assign punch_1   = act_q[0][FPunch];
  assign kick_1    = act_q[0][FKick];
  assign jump_1    = act_q[0][FJump];
  assign forward_2 = act_q[1][FFwd];
  assign back_2    = act_q[1][FBack];
  assign squat_2   = act_q[1][FSquat];
  assign punch_2   = act_q[1][FPunch];
  assign kick_2    = act_q[1][FKick];
  assign jump_2    = act_q[1][FJump];

endmodule

// File: tb/tb_kof_input_decoder.sv
// Scoreboard bench for kof_input_decoder: each frame pushes its hand-computed
// action vector; a monitor pops and compares after every vsync rise or reset.
module tb_kof_input_decoder;

  // Expected-vector bit layout {f1,b1,s1,p1,k1,j1,f2,b2,s2,p2,k2,j2}.
  localparam logic [11:0] F1 = 12'h800, B1 = 12'h400, S1 = 12'h200;
  localparam logic [11:0] P1 = 12'h100, K1 = 12'h080, J1 = 12'h040;
  localparam logic [11:0] F2 = 12'h020, B2 = 12'h010, S2 = 12'h008;
  localparam logic [11:0] P2 = 12'h004, J2 = 12'h001;

  typedef struct {
    logic [11:0] v;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vsync = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] kc0 = '0;
  logic [31:0] kc1 = '0;
  logic forward_1, back_1, squat_1, punch_1, kick_1, jump_1;
  logic forward_2, back_2, squat_2, punch_2, kick_2, jump_2;
  logic [11:0] act;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   next_id = 0;

  kof_input_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .keycode0_gpio(kc0),
    .keycode1_gpio(kc1),
    .vsync        (vsync),
    .stop         (stop),
    .forward_1    (forward_1),
    .back_1       (back_1),
    .squat_1      (squat_1),
    .punch_1      (punch_1),
    .kick_1       (kick_1),
    .jump_1       (jump_1),
    .forward_2    (forward_2),
    .back_2       (back_2),
    .squat_2      (squat_2),
    .punch_2      (punch_2),
    .kick_2       (kick_2),
    .jump_2       (jump_2)
  );

  always #5 clk = ~clk;

  assign act = {forward_1, back_1, squat_1, punch_1, kick_1, jump_1,
                forward_2, back_2, squat_2, punch_2, kick_2, jump_2};

  task automatic push_exp(input logic [11:0] v);
    exp_t e;
    e.v  = v;
    e.id = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_underrun got=%03h", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e.v) begin
        failures++;
        $display("FAIL step%0d got=%03h exp=%03h", e.id, act, e.v);
      end
    end
  endtask

  // Monitor: outputs settle on the 3rd clk after vsync rises; sample after the 4th.
  initial begin
    forever begin
      @(posedge vsync or posedge reset);
      if (reset) begin
        #1;
      end else begin
        repeat (4) @(posedge clk);
        @(negedge clk);
      end
      compare_head();
    end
  end

  task automatic frame(input logic [31:0] k0, input logic [31:0] k1, input logic s,
                       input logic [11:0] e);
    @(negedge clk);
    kc0  = k0;
    kc1  = k1;
    stop = s;
    push_exp(e);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reset(input logic [11:0] e);
    @(negedge clk);
    push_exp(e);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    pulse_reset(12'h000);

    // Directional levels and conflict resolution.
    frame(32'h0000_0007, 32'h0, 1'b0, F1);
    frame(32'h0000_0000, 32'h0, 1'b0, 12'h000);
    frame(32'h0000_0704, 32'h0, 1'b0, 12'h000);
    frame(32'h0016_0704, 32'h0, 1'b0, S1);

    // Punch one-shot and cooldown (12): accept, lockout discard, accept at +13.
    frame(32'h0000_000D, 32'h0, 1'b0, P1);
    for (int i = 0; i < 3; i++) frame(32'h0000_000D, 32'h0, 1'b0, 12'h000);
    for (int i = 0; i < 3; i++) frame(32'h0, 32'h0, 1'b0, 12'h000);
    frame(32'h0000_000D, 32'h0, 1'b0, 12'h000);
    frame(32'h0000_000D, 32'h0, 1'b0, 12'h000);
    for (int i = 0; i < 4; i++) frame(32'h0, 32'h0, 1'b0, 12'h000);
    frame(32'h0000_000D, 32'h0, 1'b0, P1);
    frame(32'h0000_000D, 32'h0, 1'b0, 12'h000);
    for (int i = 0; i < 12; i++) frame(32'h0, 32'h0, 1'b0, 12'h000);

    // Punch beats kick in the same frame; player-2 jump with lockout.
    frame(32'h0000_0E0D, 32'h0000_0052, 1'b0, P1 | J2);
    frame(32'h0000_0E0D, 32'h0000_0052, 1'b0, 12'h000);
    frame(32'h0, 32'h0, 1'b0, 12'h000);
    frame(32'h0, 32'h0000_0052, 1'b0, 12'h000);

    // Stop forces zeros, absorbs presses, and freezes counters.
    frame(32'h0000_071A, 32'h0, 1'b1, 12'h000);
    frame(32'h0, 32'h0, 1'b1, 12'h000);
    frame(32'h0, 32'h0, 1'b0, 12'h000);
    frame(32'h0000_001A, 32'h0, 1'b1, 12'h000);
    frame(32'h0000_001A, 32'h0, 1'b0, 12'h000);
    frame(32'h0, 32'h0, 1'b0, 12'h000);
    frame(32'h0000_001A, 32'h0, 1'b0, J1);
    // Attack counter is 5 here only if the three stop ticks froze it.
    for (int i = 0; i < 4; i++) frame(32'h0, 32'h0, 1'b0, 12'h000);
    frame(32'h0000_000E, 32'h0, 1'b0, 12'h000);
    frame(32'h0, 32'h0, 1'b0, 12'h000);
    frame(32'h0000_000E, 32'h0, 1'b0, K1);

    // Asynchronous reset mid-frame; held keys re-fire afterwards.
    frame(32'h0, 32'h0000_5950, 1'b0, F2 | P2);
    frame(32'h0, 32'h0000_5950, 1'b0, F2);
    pulse_reset(12'h000);
    frame(32'h0, 32'h0000_5950, 1'b0, F2 | P2);

    // Remaining player-2 directions and upper key slots; keycode1[31:16] ignored.
    frame(32'h0, 32'h0000_004F, 1'b0, B2);
    frame(32'h0700_0000, 32'h0000_4F00, 1'b0, F1 | B2);
    frame(32'h0, 32'h5051_0051, 1'b0, S2);

    repeat (10) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kof_input_decoder.md
Name: kof_input_decoder

Overview:
- Converts the raw USB keycode words from the MicroBlaze GPIO into per-player, frame-aligned fighter action strobes (forward/back/squat/punch/kick/jump for players 1 and 2).
- Sits directly upstream of the character movement/animation block, which consumes the 12 action signals once per frame.
- Adds frame alignment to vsync, press-edge one-shots for attacks and jumps, directional conflict resolution, and attack/jump lockout counters.

Parameters:
- P1_KEYMAP, 48'h07_04_16_1A_0D_0E, player-1 keycodes packed {fwd,back,squat,jump,punch,kick}; defaults are D,A,S,W,J,K.
- P2_KEYMAP, 48'h50_4F_51_52_59_5A, player-2 keycodes packed {fwd,back,squat,jump,punch,kick}; defaults are Left,Right,Down,Up,KP1,KP2 (player 2 faces left).
- ATK_COOLDOWN, 12, frames of punch/kick lockout after an accepted attack; range 0..255.
- JUMP_LOCK, 30, frames of jump lockout after an accepted jump; range 0..255.

Ports:
- clk  in  1  system clock; the 100 MHz Clk domain of the GPIO.
- reset  in  1  asynchronous, active-high reset.
- keycode0_gpio  in  32  key slots 0-3, one byte each: [7:0],[15:8],[23:16],[31:24].
- keycode1_gpio  in  32  key slots 4-5 in [7:0],[15:8]; bits [31:16] are ignored.
- vsync  in  1  VGA vsync from the 25 MHz domain; asynchronous to clk.
- stop  in  1  round-over freeze from the timer/HP logic; level-sensitive.
- forward_1, back_1, squat_1, punch_1, kick_1, jump_1  out  1 each  player-1 actions, registered.
- forward_2, back_2, squat_2, punch_2, kick_2, jump_2  out  1 each  player-2 actions, registered.

Behaviour:
- Reset (async, active-high): all 12 outputs 0; sync flops, previous-held flags and both lockout counters per player cleared to 0.
- Key matching: a function is "held" when any of the 6 slots equals its keycode. Keycode 0x00 never matches, even if a map entry is 0x00. Matching is combinational on the current GPIO value.
- Frame tick: vsync passes through a 2-flop synchronizer (s1, s2) plus a delay flop s3; tick = s2 & ~s3.
  - All state updates happen only on clk edges where tick=1; there is exactly one tick per vsync rising edge.
  - Latency: outputs change on the 3rd clk edge after vsync rises (±1 cycle of synchronizer uncertainty).
  - Outputs hold constant between ticks.
- Per player, on each tick with stop=0:
  - Level actions: squat = squat_held. forward = fwd_held & ~back_held & ~squat_held. back = back_held & ~fwd_held & ~squat_held. Forward+back together gives both 0.
  - Press edge for a function = held now & ~prev_held.
  - Attacks: if atk_cnt==0 and a punch edge occurs, punch=1 for this frame only and atk_cnt loads ATK_COOLDOWN. Otherwise, if atk_cnt==0 and a kick edge occurs, kick=1 and atk_cnt loads ATK_COOLDOWN. Punch wins when both edges arrive in the same frame. Edges that arrive during lockout are discarded, not queued.
  - Jump: if jump_cnt==0 and a jump edge occurs, jump=1 for one frame and jump_cnt loads JUMP_LOCK. Jump is independent of attacks.
  - A nonzero counter decrements by 1 per tick, saturating at 0. The counter load takes precedence over the decrement.
  - With cooldown N, the next attack is accepted no earlier than N+1 ticks after the accepted one.
  - prev_held is updated to the current held flags on every tick.
- On a tick with stop=1: all 12 outputs 0; prev_held is still updated, so keys held through a stop do not fire on release; counters freeze.
- Players are fully independent. The same keycode may appear in both maps; each player then decodes it.
- A reset mid-frame clears everything immediately; the first tick after reset sees prev_held=0, so keys already held produce edges on that tick.
- Width rules: counters are 8-bit unsigned, and each slot compare is a full 8-bit equality.

Test Plan:
- Reset, then keycode0=0x0000_0007 and pulse vsync -> forward_1=1 within 4 clk of vsync rise, all other outputs 0. Clear keycode0, next vsync -> forward_1=0.
- keycode0=0x0000_0704 (D+A) -> forward_1=0, back_1=0. Add 0x16 in slot 2 -> squat_1=1, forward_1=0, back_1=0.
- Hold 0x0D for 20 frames -> punch_1=1 only in frame 1. Release at frame 5 and re-press at frame 8 -> no punch. Re-press at frame 14 (>=13 ticks after the accept) -> punch_1=1 for one frame.
- 0x0D and 0x0E pressed in the same frame -> punch_1=1, kick_1=0. Simultaneously, keycode1=0x0000_0052 -> jump_2=1 for one frame; re-press within 30 frames -> ignored.
- stop=1 while 0x1A (W) is pressed and released -> all outputs 0 and no jump_1 after stop drops. With W still held at stop fall -> no jump_1 until released and re-pressed.
- Assert reset between two vsyncs while forward_2=1 -> forward_2=0 immediately (async). Keep 0x50 held -> forward_2=1 again on the first vsync after reset deasserts.
